sga_direction_input: RTL and testbench

SGA_DIRECTION_INPUT -- requirements
Module: sga_direction_input

---
 rtl/sga_pkg.sv | 34 +++
 rtl/sga_debounce.sv | 72 +++++++
 rtl/sga_direction_input.sv | 150 +++++++++++++++
 tb/tb_sga_direction_input.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sga_pkg.sv
// -----------------------------------------------------------------------------
// sga_pkg
// Shared definitions for the snake-game direction input path.
//   - dir_t            : 2-bit movement direction encoding
//   - DEBOUNCE_DEFAULT : default debounce window (1 ms at 50 MHz)
//   - QUEUE_DEPTH_MAX  : depth of the pending-turn queue in this revision
//   - opposite()       : true when two directions point along the same axis
//                        in opposite senses
//   - same_axis()      : true when a turn would be a no-op or a reversal
// -----------------------------------------------------------------------------
package sga_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam int DEBOUNCE_DEFAULT = 50000;
    localparam int QUEUE_DEPTH_MAX  = 2;

    // Bit 1 selects the axis (horizontal/vertical), bit 0 the sense.
    function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    // A turn onto the current axis is either "keep going" or "reverse";
    // neither is a legal turn for the snake.
    function automatic logic same_axis(input logic [1:0] a, input logic [1:0] b);
        return (a == b) || opposite(a, b);
    endfunction

endpackage

// File: rtl/sga_debounce.sv
// -----------------------------------------------------------------------------
// sga_debounce
// Two-flop synchronizer followed by a stability debouncer for one push button.
// The debounced level only follows the synchronized input after it has
// differed from the level for DEBOUNCE_CYCLES consecutive cycles; any bounce
// back reloads the timer. A one-cycle press pulse is produced on the rising
// edge of the debounced level.
//
// Ports
//   clock   in   system clock, rising edge
//   restart in   synchronous active-high reset
//   raw     in   asynchronous button input, active-high
//   press   out  one-cycle pulse when the debounced level rises
// -----------------------------------------------------------------------------
module sga_debounce
    import sga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic restart,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [1:0]    fill;
    logic          armed;
    logic          level;
    logic [CW-1:0] cnt;

    // fill[1] marks that sync_2 holds a real sample rather than its reset
    // value. A button is armed only once it has been seen released after
    // reset, so a button held through reset cannot produce a press.
    always_ff @(posedge clock) begin
        if (restart) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            fill   <= 2'b00;
            armed  <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            fill   <= {fill[0], 1'b1};
            press  <= 1'b0;

            if (fill[1] && !sync_2) begin
                armed <= 1'b1;
            end

            // Down-counter: reload while stable, flip the level when it
            // reaches terminal count with the input still different.
            if (sync_2 == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync_2;
                cnt   <= RELOAD;
                press <= sync_2 & armed;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sga_direction_input.sv
// -----------------------------------------------------------------------------
// sga_direction_input
// Turns four raw direction buttons into a small queue of legal turns for the
// snake, and commits the queued turns to the movement direction when the
// control unit steps the head.
//
// Ports
//   clock     in   system clock, rising edge
//   restart   in   synchronous active-high reset
//   enable    in   game is accepting moves
//   left      in   raw button, active-high
//   right     in   raw button, active-high
//   up        in   raw button, active-high
//   down      in   raw button, active-high
//   consume   in   one-cycle pulse: take the next queued turn
//   direction out  committed movement direction (RIGHT=00 LEFT=01 DOWN=10 UP=11)
//   played    out  one-cycle pulse when a turn was accepted into the queue
//   pending   out  number of queued turns (0..2)
// -----------------------------------------------------------------------------
module sga_direction_input
    import sga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int QUEUE_DEPTH     = QUEUE_DEPTH_MAX
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       enable,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       consume,
    output logic [1:0] direction,
    output logic       played,
    output logic [1:0] pending
);

    localparam logic [1:0] QDEPTH = QUEUE_DEPTH[1:0];

    logic press_left;
    logic press_right;
    logic press_up;
    logic press_down;

    sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clock   (clock),
        .restart (restart),
        .raw     (left),
        .press   (press_left)
    );

    sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clock   (clock),
        .restart (restart),
        .raw     (right),
        .press   (press_right)
    );

    sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock   (clock),
        .restart (restart),
        .raw     (up),
        .press   (press_up)
    );

    sga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock   (clock),
        .restart (restart),
        .raw     (down),
        .press   (press_down)
    );

    // Queue: q_head is the oldest turn, q_tail_slot the second one.
    logic [1:0] q_head;
    logic [1:0] q_tail_slot;

    logic       press_any;
    logic [1:0] press_dir;
    logic       pop;
    logic [1:0] cnt_after;
    logic [1:0] dir_next;
    logic [1:0] head_after;
    logic [1:0] ref_dir;
    logic       accept;
    logic [1:0] head_next;
    logic [1:0] tail_next;
    logic [1:0] pending_next;

    // Simultaneous presses collapse to one, UP > DOWN > LEFT > RIGHT.
    always_comb begin
        press_any = press_up | press_down | press_left | press_right;
        press_dir = DIR_RIGHT;
        if (press_up) begin
            press_dir = DIR_UP;
        end else if (press_down) begin
            press_dir = DIR_DOWN;
        end else if (press_left) begin
            press_dir = DIR_LEFT;
        end
    end

    // The pop is resolved first so that the push sees the post-pop queue and
    // direction; this is what lets a full queue accept a turn on a consume.
    always_comb begin
        pop        = consume && (pending != 2'd0);
        cnt_after  = pending - {1'b0, pop};
        dir_next   = pop ? q_head : direction;
        head_after = pop ? q_tail_slot : q_head;

        ref_dir = dir_next;
        if (cnt_after == 2'd1) begin
            ref_dir = head_after;
        end else if (cnt_after >= 2'd2) begin
            ref_dir = q_tail_slot;
        end

        accept = enable && press_any
                 && !same_axis(press_dir, ref_dir)
                 && (cnt_after < QDEPTH);

        head_next = head_after;
        tail_next = q_tail_slot;
        if (accept && (cnt_after == 2'd0)) begin
            head_next = press_dir;
        end
        if (accept && (cnt_after == 2'd1)) begin
            tail_next = press_dir;
        end

        pending_next = cnt_after + {1'b0, accept};
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            direction   <= DIR_RIGHT;
            q_head      <= 2'b00;
            q_tail_slot <= 2'b00;
            pending     <= 2'd0;
            played      <= 1'b0;
        end else begin
            direction   <= dir_next;
            q_head      <= head_next;
            q_tail_slot <= tail_next;
            pending     <= pending_next;
            played      <= accept;
        end
    end

endmodule

// File: tb/tb_sga_direction_input.sv
module tb_sga_direction_input;

    logic       clock = 1'b0;
    logic       restart;
    logic       enable;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       consume;
    logic [1:0] direction;
    logic       played;
    logic [1:0] pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pcount   = 0;
    int plast    = -1;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    sga_direction_input #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2)) dut (
        .clock     (clock),
        .restart   (restart),
        .enable    (enable),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .consume   (consume),
        .direction (direction),
        .played    (played),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (played) begin
            pcount++;
            plast = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        up    = m[3];
        down  = m[2];
        left  = m[1];
        right = m[0];
    endtask

    // Press, hold long enough to be accepted, release and let it settle.
    task automatic tap(input logic [3:0] m);
        set_btn(m);
        tick(8);
        set_btn(4'b0000);
        tick(8);
    endtask

    task automatic do_consume();
        consume = 1'b1;
        tick(1);
        consume = 1'b0;
    endtask

    task automatic do_reset();
        restart = 1'b1;
        tick(2);
        restart = 1'b0;
        tick(3);
    endtask

    int c0;
    int p0;

    initial begin
        restart = 1'b1;
        enable  = 1'b1;
        consume = 1'b0;
        set_btn(4'b0000);
        tick(3);
        chk("rst_dir", direction, 0);
        chk("rst_pending", pending, 0);
        chk("rst_played", played, 0);
        restart = 1'b0;
        tick(3);

        // UP held 10 cycles: exactly one played, 7 cycles after the edge
        p0 = pcount;
        c0 = cyc;
        up = 1'b1;
        tick(10);
        up = 1'b0;
        chk("up_played_once", pcount - p0, 1);
        chk("up_latency", plast - c0, 7);
        chk("up_pending", pending, 1);
        tick(8);
        do_consume();
        chk("up_consume_dir", direction, 3);
        chk("up_consume_pending", pending, 0);

        // From RIGHT: LEFT (opposite) and RIGHT (same) are dropped
        do_reset();
        p0 = pcount;
        tap(B_LEFT);
        chk("left_drop_played", pcount - p0, 0);
        chk("left_drop_pending", pending, 0);
        tap(B_RIGHT);
        chk("right_drop_played", pcount - p0, 0);
        chk("right_drop_pending", pending, 0);

        // UP, LEFT queued; DOWN dropped as full
        tap(B_UP);
        tap(B_LEFT);
        chk("q2_pending", pending, 2);
        tap(B_DOWN);
        chk("full_played", pcount - p0, 2);
        chk("full_pending", pending, 2);
        do_consume();
        chk("pop1_dir", direction, 3);
        chk("pop1_pending", pending, 1);
        do_consume();
        chk("pop2_dir", direction, 1);
        chk("pop2_pending", pending, 0);
        do_consume();
        chk("empty_consume_dir", direction, 1);
        chk("empty_consume_pending", pending, 0);

        // 2-cycle glitch on down: no event (DOWN would be legal from LEFT)
        p0 = pcount;
        down = 1'b1;
        tick(2);
        down = 1'b0;
        tick(10);
        chk("glitch_played", pcount - p0, 0);
        chk("glitch_pending", pending, 0);

        // UP and LEFT together: only UP taken
        tap(B_UP | B_LEFT);
        chk("prio_played", pcount - p0, 1);
        chk("prio_pending", pending, 1);
        do_consume();
        chk("prio_dir", direction, 3);

        // Full [UP, LEFT] + consume + DOWN in the same cycle
        do_reset();
        tap(B_UP);
        tap(B_LEFT);
        chk("fc_pre_pending", pending, 2);
        p0 = pcount;
        down = 1'b1;
        tick(6);
        consume = 1'b1;
        tick(1);
        consume = 1'b0;
        chk("fc_dir", direction, 3);
        chk("fc_pending", pending, 2);
        chk("fc_played", played, 1);
        tick(1);
        down = 1'b0;
        tick(8);
        chk("fc_played_cnt", pcount - p0, 1);
        do_consume();
        chk("fc_pop1_dir", direction, 1);
        do_consume();
        chk("fc_pop2_dir", direction, 2);
        chk("fc_pop2_pending", pending, 0);

        // enable=0: press dropped, consume still honoured
        tap(B_LEFT);
        chk("en_q_pending", pending, 1);
        enable = 1'b0;
        p0 = pcount;
        tap(B_UP);
        chk("en0_played", pcount - p0, 0);
        chk("en0_pending", pending, 1);
        do_consume();
        chk("en0_consume_dir", direction, 1);
        chk("en0_consume_pending", pending, 0);
        enable = 1'b1;

        // Restart while pending=2
        tap(B_UP);
        tap(B_RIGHT);
        chk("rst2_pre_pending", pending, 2);
        restart = 1'b1;
        consume = 1'b1;
        tick(1);
        consume = 1'b0;
        chk("rst2_dir", direction, 0);
        chk("rst2_pending", pending, 0);
        chk("rst2_played", played, 0);

        // UP held through reset: no event until released and pressed again
        up = 1'b1;
        tick(2);
        restart = 1'b0;
        p0 = pcount;
        tick(14);
        chk("held_played", pcount - p0, 0);
        chk("held_pending", pending, 0);
        up = 1'b0;
        tick(8);
        tap(B_UP);
        chk("repress_played", pcount - p0, 1);
        chk("repress_pending", pending, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
